// File: rtl/wino_pkg.sv
// wino_pkg: shared definitions for the Winograd datapath blocks.
//   OUT_TILE / OUT_ELEMS : output tile geometry (4x4 = 16 elements)
//   RESULT_W_DEF/DEPTH_DEF: default accumulator width and result memory depth
//   res_state_e          : result_mem_controller pass state
//   result_tile_t        : one packed 4x4 accumulated tile (512 bits)
package wino_pkg;
    localparam int OUT_TILE     = 4;
    localparam int OUT_ELEMS    = OUT_TILE * OUT_TILE;
    localparam int RESULT_W_DEF = 32;
    localparam int DEPTH_DEF    = 256;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH
    } res_state_e;

    // Element [r][c] lives at index r*OUT_TILE+c.
    typedef logic [OUT_ELEMS-1:0][RESULT_W_DEF-1:0] result_tile_t;
endpackage

// File: rtl/result_ram.sv
// result_ram: 1R1W synchronous RAM, DEPTH x one result tile, registered read.
// A read and a write to the same entry on one edge return the old contents.
// No reset; contents are undefined until written.
//   clk         : clock
//   raddr/rdata : read address, registered read data
//   we/waddr/wdata : write port
module result_ram
    import wino_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic [AW-1:0] raddr,
    output result_tile_t rdata,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  result_tile_t wdata
);
    result_tile_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/result_mem_controller.sv
// result_mem_controller: accumulates 4x4 Winograd output tiles from the PE
// arrays into a DEPTH-entry result memory across input channels, and reads
// entries back over a 512-bit scan port.
//   clk, reset          : clock, synchronous active-high reset
//   pass_start_i        : pulse, starts a pass (samples first_channel_i, tile_total_i)
//   first_channel_i     : 1 = overwrite, 0 = accumulate
//   tile_total_i        : tiles in the pass, 0 = 256
//   tile_i/tile_addr_i/tile_valid_i/tile_ready_o : tile input handshake
//   pass_done_o         : pulse once the last tile is written
//   busy_o              : pass in progress
//   scan_mode/scan_addr/scan_out : registered readback (2 cycles), holds when idle
// Build option: define RESULT_SAT_EN to make the accumulator saturate instead
// of wrapping.
module result_mem_controller
    import wino_pkg::*;
#(
    parameter int RESULT_W  = RESULT_W_DEF,   // 16*RESULT_W must be 512
    parameter int TILE_IN_W = 20,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic pass_start_i,
    input  logic first_channel_i,
    input  logic [7:0] tile_total_i,
    input  logic signed [OUT_TILE-1:0][OUT_TILE-1:0][TILE_IN_W-1:0] tile_i,
    input  logic [7:0] tile_addr_i,
    input  logic tile_valid_i,
    output logic tile_ready_o,
    output logic pass_done_o,
    output logic busy_o,
    input  logic scan_mode,
    input  logic [7:0] scan_addr,
    output logic [511:0] scan_out
);
    localparam int AW     = $clog2(DEPTH);
    localparam int STAGES = 2;

    res_state_e state;
    logic       first_r;
    logic [8:0] total_r, cnt;
    logic       accept;
    logic [STAGES:1] vld_pipe;

    logic [AW-1:0] s0_addr, s1_addr, s2_addr, rd_addr;
    logic          s1_first, s1_fwd, s0_hit1, s0_hit2, scan_rd_q;
    result_tile_t  s0_ext, s1_tile, s1_fwd_data, s1_sum, s2_data, rd_data;

    assign tile_ready_o = (state == ACCUM) && !scan_mode;
    assign accept       = tile_valid_i && tile_ready_o;
    assign s0_addr      = tile_addr_i[AW-1:0];
    // Scan owns the read port; no tile can be accepted while scan_mode is high.
    assign rd_addr      = scan_mode ? scan_addr[AW-1:0] : s0_addr;

    // RAM read for S0 misses both the S1 result (not written yet) and the S2
    // write landing on the same edge, so either is captured for S1 instead.
    assign s0_hit1 = vld_pipe[1] && (s1_addr == s0_addr);
    assign s0_hit2 = vld_pipe[2] && (s2_addr == s0_addr);

    for (genvar e = 0; e < OUT_ELEMS; e++) begin : g_elem
        logic [TILE_IN_W-1:0] raw;
        logic [RESULT_W-1:0]  old_v;
        logic [RESULT_W:0]    wide;

        assign raw       = tile_i[e/OUT_TILE][e%OUT_TILE];
        assign s0_ext[e] = {{(RESULT_W-TILE_IN_W){raw[TILE_IN_W-1]}}, raw};
        assign old_v     = s1_first ? '0 : (s1_fwd ? s1_fwd_data[e] : rd_data[e]);
        assign wide      = {old_v[RESULT_W-1], old_v} + {s1_tile[e][RESULT_W-1], s1_tile[e]};
`ifdef RESULT_SAT_EN
        // Top two bits of the widened sum disagree only on signed overflow.
        assign s1_sum[e] = (wide[RESULT_W] != wide[RESULT_W-1])
                         ? (wide[RESULT_W] ? {1'b1, {(RESULT_W-1){1'b0}}}
                                           : {1'b0, {(RESULT_W-1){1'b1}}})
                         : wide[RESULT_W-1:0];
`else
        assign s1_sum[e] = wide[RESULT_W-1:0];
`endif
    end

    // Write in S2 is suppressed on the reset edge so a mid-pass reset drops it.
    result_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .raddr (rd_addr),
        .rdata (rd_data),
        .we    (vld_pipe[2] && !reset),
        .waddr (s2_addr),
        .wdata (s2_data)
    );

    // RMW pipeline: S0 accept/read, S1 add, S2 write.
    always_ff @(posedge clk) begin
        if (reset)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[1], accept};
        if (accept) begin
            s1_addr     <= s0_addr;
            s1_tile     <= s0_ext;
            s1_first    <= first_r;
            s1_fwd      <= s0_hit1 || s0_hit2;
            s1_fwd_data <= s0_hit1 ? s1_sum : s2_data;
        end
        if (vld_pipe[1]) begin
            s2_addr <= s1_addr;
            s2_data <= s1_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            first_r     <= 1'b0;
            total_r     <= '0;
            cnt         <= '0;
            busy_o      <= 1'b0;
            pass_done_o <= 1'b0;
        end else begin
            pass_done_o <= 1'b0;
            case (state)
                IDLE: if (pass_start_i && !scan_mode) begin
                    state   <= ACCUM;
                    busy_o  <= 1'b1;
                    cnt     <= '0;
                    first_r <= first_channel_i;
                    total_r <= (tile_total_i == 8'd0) ? 9'd256 : {1'b0, tile_total_i};
                end
                ACCUM: if (accept) begin
                    cnt <= cnt + 9'd1;
                    if (cnt + 9'd1 == total_r)
                        state <= FLUSH;
                end
                FLUSH: if (vld_pipe == '0) begin
                    state       <= IDLE;
                    busy_o      <= 1'b0;
                    pass_done_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // scan_rd_q marks that rd_data now holds a scan read.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_rd_q <= 1'b0;
            scan_out  <= '0;
        end else begin
            scan_rd_q <= scan_mode;
            if (scan_rd_q)
                scan_out <= rd_data;
        end
    end
endmodule

// File: doc/result_mem_controller.md
# result_mem_controller

Receives Winograd output tiles (4x4 signed elements) from the PE arrays and accumulates them across input channels into a 256-entry on-chip result memory. Once a layer pass is complete, reads them back out over a 512-bit scan port. It is the return path of the data memory controller: that block scan-writes input data and streams 6x6 tiles to the PEs, and this block collects the PE results and scan-reads them out.

## Interface
- `RESULT_W`, default 32: accumulated element width in bits. 16 x `RESULT_W` must equal 512.
- `TILE_IN_W`, default 20: signed width of incoming PE result elements.
- `DEPTH`, default 256: number of result memory entries, one 4x4 tile per entry.
- `clk`, input, 1: the only clock; also clocks the scan port.
- `reset`, input, 1: synchronous, active-high.
- `pass_start_i`, input, 1: one-cycle pulse that starts an accumulation pass.
- `first_channel_i`, input, 1: sampled with `pass_start_i`. When 1, incoming tiles overwrite memory; when 0, they are added to it.
- `tile_total_i`, input, 8: sampled with `pass_start_i`. Number of tiles expected in the pass; 0 means 256.
- `tile_i`, input, 16x`TILE_IN_W` signed (`[3:0][3:0]`): result tile from a PE array.
- `tile_addr_i`, input, 8: memory entry for `tile_i`.
- `tile_valid_i`, input, 1: `tile_i` and `tile_addr_i` are valid.
- `tile_ready_o`, output, 1: a tile is accepted on any cycle where `tile_valid_i` and `tile_ready_o` are both 1.
- `pass_done_o`, output, 1: one-cycle pulse when the last tile of the pass has been written.
- `busy_o`, output, 1: high while a pass is in progress.
- `scan_mode`, input, 1: selects scan-out readback.
- `scan_addr`, input, 8: entry to read.
- `scan_out`, output, 512: entry contents; element `[r][c]` sits at bits `(r*4+c)*RESULT_W +: RESULT_W`.

## Operation
- State machine states: IDLE, ACCUM, FLUSH.
  - IDLE to ACCUM on `pass_start_i` when `scan_mode` is 0.
  - ACCUM to FLUSH when the accepted-tile count reaches `tile_total_i`.
  - FLUSH to IDLE when the pipeline is empty; `pass_done_o` pulses on the same cycle.
- `tile_ready_o` is 1 only in ACCUM with `scan_mode` 0. It is combinational from state and `scan_mode`, never from `tile_valid_i`.
- Read-modify-write pipeline, three stages:
  - S0: accept the tile and issue the memory read.
  - S1: read data returns; add or overwrite.
  - S2: write back.
  - Sustains one tile per cycle.
- Incoming elements are sign-extended from `TILE_IN_W` to `RESULT_W` before the add.
- Hazard handling: if the S1 or S2 address equals the S0 address, the newest in-flight value is forwarded in place of the memory read data. S2 forwarding has priority over stale memory data, and S1 over S2. Back-to-back tiles to the same address must accumulate exactly.
- `pass_start_i` outside IDLE is ignored.
- `scan_mode` rising while in ACCUM or FLUSH: new tiles are stalled through `tile_ready_o`, in-flight tiles still complete, and the pass resumes when `scan_mode` falls.
- The scan read port is shared with S0. Scan reads take priority, and S0 issues no read while `scan_mode` is 1.
- Memory contents are not reset and are undefined until the first pass with `first_channel_i` = 1.
- Reset mid-pass: state returns to IDLE, the pipeline valid bits clear, the tile count clears, and a write in flight in S2 is dropped.

## Timing
- Reset values: `tile_ready_o` = 0, `pass_done_o` = 0, `busy_o` = 0, `scan_out` = 0.
- `busy_o` rises the cycle after `pass_start_i` and falls together with the `pass_done_o` pulse.
- Latency from tile acceptance to memory write is 2 cycles. `pass_done_o` fires 3 cycles after the final tile is accepted.
- `scan_out` is registered: data for `scan_addr` sampled at edge N appears after edge N+1. `scan_out` holds its value while `scan_mode` is 0.

## Configuration
- `RESULT_SAT_EN` defined: the S1 adder saturates to the signed `RESULT_W` range, so it clamps at 0x7FFFFFFF and 0x80000000.
- `RESULT_SAT_EN` undefined: two's-complement wrap-around.

## Structure
- Shared package `wino_pkg` holds:
  - tile dimension constants (`OUT_TILE = 4`);
  - `RESULT_W` and `DEPTH` defaults;
  - the state enum `res_state_e`;
  - typedef `result_tile_t`, a packed 16-element array.
- Sub-module `result_ram`: a 1R1W synchronous RAM, `DEPTH` x 512, with read data registered. Behavioural model only; no reset.

## Test plan
- Overwrite then readback: start a pass with `first_channel_i` = 1 and `tile_total_i` = 2, writing tile all-5 to address 3 and tile all-(-2) to address 7.
  - `pass_done_o` pulses 3 cycles after the last accept.
  - Scan address 3 returns every element = 5; address 7 returns every element = 0xFFFFFFFE.
- Accumulation: run the same pass again with `first_channel_i` = 0. Address 3 then reads 10 per element.
- Forwarding hazard: overwrite pass with `tile_total_i` = 4, then an add pass of four back-to-back tiles of all-1 to address 9. Address 9 ends at 4 per element.
- Scan interrupt: raise `scan_mode` for 5 cycles during a 6-tile pass.
  - `tile_ready_o` is 0 during the interrupt.
  - All 6 tiles land and `pass_done_o` pulses exactly once.
- Saturation: add 0x7FFFFFF0 and 0x20 into one element.
  - With `RESULT_SAT_EN`: reads 0x7FFFFFFF.
  - Without it: reads 0x80000010.
- Reset mid-pass: assert `reset` 1 cycle after the second of 4 tiles is accepted.
  - Next cycle: `busy_o` = 0, `tile_ready_o` = 0, and no `pass_done_o`.
  - A new pass then completes normally.
